// File: rtl/left_barrel_shifter_pipe.sv
// Three-stage pipelined 8-bit left rotator (4/2/1 steps) with valid/ready flow control.
// Define LSL_MODE_EN to add a per-request `mode` input selecting logical shift (1) or rotate (0).
module left_barrel_shifter_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    input  logic [2:0] amt,
`ifdef LSL_MODE_EN
    input  logic       mode,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out
);

    function automatic logic [7:0] step4(input logic [7:0] d, input logic en, input logic lsl);
        if (!en) return d;
        return lsl ? {d[3:0], 4'h0} : {d[3:0], d[7:4]};
    endfunction

    function automatic logic [7:0] step2(input logic [7:0] d, input logic en, input logic lsl);
        if (!en) return d;
        return lsl ? {d[5:0], 2'b00} : {d[5:0], d[7:6]};
    endfunction

    function automatic logic [7:0] step1(input logic [7:0] d, input logic en, input logic lsl);
        if (!en) return d;
        return lsl ? {d[6:0], 1'b0} : {d[6:0], d[7]};
    endfunction

    logic       req_mode;
`ifdef LSL_MODE_EN
    assign req_mode = mode;
`else
    assign req_mode = 1'b0;
`endif

    logic       s1_valid, s2_valid, s3_valid;
    logic [7:0] s1_data, s2_data, s3_data;
    logic [1:0] s1_amt;
    logic       s2_amt;
    logic       s1_mode, s2_mode;
    logic       adv1, adv2, adv3;
    logic [7:0] s1_next, s2_next, s3_next;

    // A stage moves when it is empty or its successor moves, so bubbles collapse under stall.
    always_comb begin
        adv3     = !s3_valid || out_ready;
        adv2     = !s2_valid || adv3;
        adv1     = !s1_valid || adv2;
        in_ready = adv1 && !reset;
        s1_next  = step4(in, amt[2], req_mode);
        s2_next  = step2(s1_data, s1_amt[1], s1_mode);
        s3_next  = step1(s2_data, s2_amt, s2_mode);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_data  <= 8'h00;
            s2_data  <= 8'h00;
            s3_data  <= 8'h00;
            s1_amt   <= 2'b00;
            s2_amt   <= 1'b0;
            s1_mode  <= 1'b0;
            s2_mode  <= 1'b0;
        end else begin
            // Data registers load only with a real request, keeping out at 0 until the first result.
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= s1_next;
                    s1_amt  <= amt[1:0];
                    s1_mode <= req_mode;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s2_next;
                    s2_amt  <= s1_amt[0];
                    s2_mode <= s1_mode;
                end
            end
            if (adv3) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_data <= s3_next;
                end
            end
        end
    end

    assign out_valid = s3_valid;
    assign out       = s3_data;

endmodule

// File: tb/tb_left_barrel_shifter_pipe.sv
// Directed bench for left_barrel_shifter_pipe: hand-computed results checked in order via a queue.
module tb_left_barrel_shifter_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic [2:0] amt;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         streak     = 0;
    int         max_streak = 0;

    always #5 clk = ~clk;

    left_barrel_shifter_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .amt       (amt),
`ifdef LSL_MODE_EN
        .mode      (mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; push its hand-computed result; report cycles waited.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic m,
                        input logic [7:0] expv, output int waited);
        bit acc;
        acc      = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        din      = d;
        amt      = a;
        mode     = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            waited++;
            if (acc) break;
        end
        check("send_accept", 32'(acc), 32'd1);
        if (acc) exp_q.push_back(expv);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: compares every output transfer against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            streak = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
            else check("out_data", 32'(dout), 32'(exp_q.pop_front()));
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = 8'h00;
        amt       = 3'd0;
        mode      = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("in_ready_during_reset", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(dout), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single rotate and its latency.
        tick();
        in_valid = 1'b1;
        din      = 8'hB4;
        amt      = 3'd3;
        exp_q.push_back(8'hA5);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("rot_b4_3", 32'(dout), 32'hA5);
        drain();

        // Wrap-around and zero amount.
        send(8'h81, 3'd7, 1'b0, 8'hC0, w);
        send(8'h3C, 3'd0, 1'b0, 8'h3C, w);
        in_valid = 1'b0;
        drain();

        // Back-to-back: 8 requests, no stalls, 8 consecutive results.
        tick();
        max_streak = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = 8'h01;
            e = e << i;
            send(8'h01, 3'(i), 1'b0, e, w);
            check("b2b_no_wait", 32'(w), 32'd1);
        end
        in_valid = 1'b0;
        drain();
        check("b2b_streak", 32'(max_streak), 32'd8);

        // Backpressure: 3 accepted while stalled, 4th waits, then all emerge in order.
        out_ready = 1'b0;
        send(8'h03, 3'd1, 1'b0, 8'h06, w);
        send(8'h03, 3'd2, 1'b0, 8'h0C, w);
        send(8'h03, 3'd3, 1'b0, 8'h18, w);
        din = 8'h03;
        amt = 3'd4;
        exp_q.push_back(8'h30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_frozen", 32'(dout), 32'h06);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        drain();

        // Reset mid-stream discards everything in flight.
        out_ready = 1'b0;
        send(8'h11, 3'd1, 1'b0, 8'h22, w);
        send(8'h22, 3'd1, 1'b0, 8'h44, w);
        send(8'h44, 3'd1, 1'b0, 8'h88, w);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(dout), 32'h00);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        send(8'hB4, 3'd3, 1'b0, 8'hA5, w);
        in_valid = 1'b0;
        drain();

`ifdef LSL_MODE_EN
        send(8'hFF, 3'd4, 1'b1, 8'hF0, w);
        send(8'hFF, 3'd4, 1'b0, 8'hFF, w);
        in_valid = 1'b0;
        drain();
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
